// File: rtl/lsu_byte_seq.sv
// Byte-serial load/store sequencer: one byte per cycle to the data memory, loads reassembled little-endian and extended.
// Response N+1 cycles after accept (1 for illegal size); req_ready low from accept through the response cycle.
module lsu_byte_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [XLEN-1:0]       resp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_A,
  output logic [XLEN-1:0]       mem_WD,
  output logic                  mem_WE,
  input  logic [XLEN-1:0]       mem_RD
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            k_q, k_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [XLEN-1:0]       asm_q, asm_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [XLEN-1:0]       resp_rdata_q, resp_rdata_d;

  logic [1:0]            last_k;
  logic [XLEN-1:0]       asm_upd;
  logic                  unused_rd;

  // Only the low byte of the memory read bus carries data.
  assign unused_rd = ^mem_RD[XLEN-1:8];

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] data,
                                             input logic [1:0]      size,
                                             input logic            uns);
    logic [XLEN-1:0] keep;
    logic            sgn;
    case (size)
      2'b00: begin
        keep = XLEN'(8'hFF);
        sgn  = data[7];
      end
      2'b01: begin
        keep = XLEN'(16'hFFFF);
        sgn  = data[15];
      end
      default: begin
        keep = XLEN'(32'hFFFF_FFFF);
        sgn  = data[31];
      end
    endcase
    extend = (data & keep) | ({XLEN{sgn & ~uns}} & ~keep);
  endfunction

  always_comb begin
    case (size_q)
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

  // Assembly register with the byte arriving this cycle merged in, so the
  // final response can include the last byte without an extra cycle.
  always_comb begin
    asm_upd = asm_q;
    asm_upd[{k_q, 3'b000} +: 8] = mem_RD[7:0];
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    asm_d        = asm_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          k_d     = 2'd0;
          asm_d   = '0;
          if (req_size == 2'b11) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!we_q) begin
          asm_d = asm_upd;
        end
        k_d = k_q + 2'd1;
        if (k_q == last_k) begin
          state_d      = DONE;
          k_d          = 2'd0;
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? '0 : extend(asm_upd, size_q, uns_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      asm_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      asm_q        <= asm_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Ready is masked by reset so the pipeline sees a stall while held in reset.
  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  assign mem_WE = (state_q == ACCESS) && we_q;
  assign mem_A  = (state_q == ACCESS) ? (addr_q + ADDR_WIDTH'(k_q)) : '0;
  assign mem_WD = ((state_q == ACCESS) && we_q) ? XLEN'(wdata_q[{k_q, 3'b000} +: 8]) : '0;

endmodule

// File: doc/lsu_byte_seq.md
# lsu_byte_seq

Load/store sequencer in the memory stage of the pipelined CPU, directly upstream of the byte-wide data memory. It accepts one load or store request at a time (byte, halfword or word, signed or unsigned), breaks it into one byte access per cycle on the data memory port, and reassembles load data little-endian with sign or zero extension. While a request is in flight it holds `req_ready` low, and the pipeline uses that as its memory-stage stall.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: width of the request address and of the memory address.
- `XLEN`, default 32: width of request write data, response read data and the memory data buses.

Ports (clock and reset first). Reset is asynchronous and active-high.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: access size. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned`  in  1: loads only. 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  ADDR_WIDTH: byte address of the lowest byte.
- `req_wdata`  in  XLEN: store data, taken from the low bytes first.
- `req_ready`  out  1: block can accept a request this cycle.
- `resp_valid`  out  1: one-cycle completion pulse.
- `resp_err`  out  1: the completing request was illegal; valid while `resp_valid` is high.
- `resp_rdata`  out  XLEN: extended load data; 0 for stores and illegal requests.
- `mem_A`  out  ADDR_WIDTH: data memory byte address.
- `mem_WD`  out  XLEN: data memory write data; only bits [7:0] are meaningful, bits [31:8] are 0.
- `mem_WE`  out  1: data memory write enable.
- `mem_RD`  in  XLEN: data memory read data. Combinational from `mem_A`; only bits [7:0] are used.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - `req_ready` = 1.
  - Accept on `req_valid && req_ready`: latch addr, wdata, we, size and unsigned; clear the byte counter `k` and the assembly register.
  - Go to ACCESS if size is legal; go to DONE with the error flag set if size = 11.
- ACCESS:
  - N = 1, 2 or 4 bytes for size 00, 01, 10.
  - `mem_A` = latched addr + k, modulo 2^ADDR_WIDTH. Misaligned addresses are legal and there is no alignment trap.
  - Store: `mem_WE` = 1 and `mem_WD` = {24'b0, wdata[8k+7:8k]}.
  - Load: `mem_WE` = 0; at the clock edge, capture `mem_RD[7:0]` into assembly byte k.
  - `k` increments each cycle. After the cycle with k = N-1, go to DONE.
- DONE:
  - `resp_valid` = 1 for exactly one cycle.
  - Load `resp_rdata`: assembled N bytes. Bits above 8N are filled with 0 if unsigned, otherwise with bit 8N-1.
  - Store: `resp_rdata` = 0.
  - `resp_err` = 1 only for size 11.
  - Next state is IDLE.
- Outside ACCESS: `mem_WE` = 0, `mem_A` = 0, `mem_WD` = 0.
- `req_*` inputs are ignored unless IDLE and `req_valid` is high. Latched values are unaffected by input changes during ACCESS or DONE.
- `req_unsigned` is ignored for stores.

## Timing
- Reset, asynchronous: state = IDLE, k = 0, assembly register = 0.
  - Outputs while `rst` is high: `resp_valid` = 0, `resp_err` = 0, `resp_rdata` = 0, `mem_WE` = 0, `mem_A` = 0, `mem_WD` = 0.
  - `req_ready` = 0 while `rst` is high and 1 from the first cycle after deassertion.
- Latency from the accept edge to the `resp_valid` cycle: N+1 cycles for a legal request, 1 cycle for an illegal one.
- Throughput: one request per N+2 cycles. The DONE cycle has `req_ready` = 0, so the earliest next accept is the cycle after DONE.
- `resp_valid`, `resp_err` and `resp_rdata` are registered outputs. `req_ready` and the `mem_*` outputs decode from state and latched registers only.
- Reset during ACCESS aborts the request:
  - Bytes already written remain in memory.
  - No `resp_valid` is generated.
  - The block returns to IDLE.
- Address wrap: a word store at 0xFFFFFFFE writes 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.

## Test plan
- Store word 0xDEADBEEF at 0x00010000:
  - `mem_WE` high for 4 consecutive cycles.
  - `mem_A`/`mem_WD[7:0]` = 10000/EF, 10001/BE, 10002/AD, 10003/DE.
  - `resp_valid` on the 5th cycle after accept, `resp_rdata` = 0.
- Loads from that memory:
  - lb at 0x10003 gives 0xFFFFFFDE.
  - lbu at 0x10003 gives 0x000000DE.
  - lhu at 0x10001 gives 0x0000ADBE.
  - lh at 0x10002 gives 0xFFFFDEAD.
  - Each load drives `mem_WE` = 0 throughout.
- Hold `req_valid` high with 3 back-to-back byte loads: accepts occur 3 cycles apart, and `req_ready` is low during ACCESS and DONE.
- Word store 0x11223344 at 0xFFFFFFFE: bytes 44, 33, 22, 11 written at FFFFFFFE, FFFFFFFF, 0, 1.
- `req_size` = 11 store: `mem_WE` never asserted; the next cycle has `resp_valid` = 1, `resp_err` = 1, `resp_rdata` = 0.
- Assert `rst` after the 2nd byte of a word store:
  - Only 2 bytes are written and no `resp_valid` appears.
  - `req_ready` = 1 the cycle after `rst` deasserts.
  - A subsequent lw at the same address returns the new low 2 bytes and the old upper 2 bytes.
